// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for a single APB master.
// Captures one request at a time, drives the master command and returns the response.
module apb_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [1:0]              req,
  input  logic [1:0]              req_wr,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              gnt,
  output logic [1:0]              done,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    transfer,
  output logic                    read,
  output logic                    write,
  output logic [ADDR_WIDTH-1:0]   apb_waddr,
  output logic [ADDR_WIDTH-1:0]   apb_raddr,
  output logic [DATA_WIDTH-1:0]   apb_wdata,
  input  logic [DATA_WIDTH-1:0]   apb_rdata,
  input  logic                    error,
  input  logic                    apb_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t                  state_r;
  logic                    owner_r;
  logic                    last_gnt_r;
  logic [7:0]              timer_r;
  logic                    win_s;
  logic                    sel_wr_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;

  // Round-robin pick: on a tie the requester that did not own the last transfer wins.
  always_comb begin
    win_s = 1'b0;
    case (req)
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
      2'b11:   win_s = ~last_gnt_r;
      default: win_s = 1'b0;
    endcase
    sel_wr_s    = win_s ? req_wr[1] : req_wr[0];
    sel_addr_s  = win_s ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    sel_wdata_s = win_s ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  end

  // Grant is a same-cycle acknowledgement of the request seen in IDLE, suppressed in reset.
  always_comb begin
    gnt = 2'b00;
    if (!PRESET && (state_r == IDLE) && (req != 2'b00)) begin
      gnt = win_s ? 2'b10 : 2'b01;
    end else begin
      gnt = 2'b00;
    end
  end

  // Control FSM; all master commands and responses are registered here.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r    <= IDLE;
      owner_r    <= 1'b0;
      last_gnt_r <= 1'b1;
      timer_r    <= 8'd0;
      done       <= 2'b00;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      transfer   <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      apb_waddr  <= '0;
      apb_raddr  <= '0;
      apb_wdata  <= '0;
    end else begin
      done <= 2'b00;
      case (state_r)
        IDLE: begin
          if (req != 2'b00) begin
            owner_r   <= win_s;
            timer_r   <= 8'd0;
            transfer  <= 1'b1;
            write     <= sel_wr_s;
            read      <= ~sel_wr_s;
            apb_waddr <= sel_wr_s ? sel_addr_s : '0;
            apb_wdata <= sel_wr_s ? sel_wdata_s : '0;
            apb_raddr <= sel_wr_s ? '0 : sel_addr_s;
            state_r   <= BUSY;
          end
        end
        BUSY: begin
          // A completion on the timeout cycle takes priority over the abort.
          if (apb_done || (timer_r == TIMER_LAST)) begin
            rsp_rdata <= (apb_done && !write) ? apb_rdata : '0;
            rsp_err   <= apb_done ? error : 1'b1;
            done      <= owner_r ? 2'b10 : 2'b01;
            transfer  <= 1'b0;
            read      <= 1'b0;
            write     <= 1'b0;
            apb_waddr <= '0;
            apb_raddr <= '0;
            apb_wdata <= '0;
            state_r   <= RESP;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        RESP: begin
          last_gnt_r <= owner_r;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
